// File: rtl/uart_tx_lockgate.sv
// UART transmitter (start, DATA_BITS data LSB first, optional parity, one stop) gated by a qualified PLL lock.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_lockgate #(
   parameter int CLKS_PER_BIT = 5,
   parameter int DATA_BITS    = 8,
   parameter int LOCK_WAIT    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pll_locked,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy,
   output logic                 link_up,
   output logic                 tx_abort
);

   localparam int IDXW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [7:0]      BIT_LAST  = 8'(CLKS_PER_BIT - 1);
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(DATA_BITS - 1);
   localparam logic [15:0]     LOCK_FULL = 16'(LOCK_WAIT);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state_reg, state_next;
   logic [7:0]           bit_cnt_reg, bit_cnt_next;
   logic [IDXW-1:0]      bit_idx_reg, bit_idx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 abort_reg, abort_next;
   logic                 lk_meta, lk_s;
   logic [15:0]          lock_cnt;
   logic                 last_tick;
   logic                 accept;
`ifdef UART_TX_PARITY_EN
   logic                 parity_reg, parity_next;
`endif

   // Lock synchroniser and qualification counter; a single unlocked sample restarts qualification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk_meta  <= 1'b0;
         lk_s     <= 1'b0;
         lock_cnt <= 16'd0;
      end else begin
         lk_meta <= pll_locked;
         lk_s    <= lk_meta;
         if (!lk_s)
            lock_cnt <= 16'd0;
         else if (lock_cnt != LOCK_FULL)
            lock_cnt <= lock_cnt + 16'd1;
      end
   end

   assign link_up   = (lock_cnt == LOCK_FULL);
   assign last_tick = (bit_cnt_reg == BIT_LAST);
   assign tx_ready  = link_up & ((state_reg == IDLE) | ((state_reg == STOP) & last_tick));
   assign accept    = tx_valid & tx_ready;
   assign tx_busy   = (state_reg != IDLE);
   assign tx_abort  = abort_reg;

   always_comb begin
      txd = 1'b1;
      case (state_reg)
         START:   txd = 1'b0;
         DATA:    txd = shift_reg[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  txd = parity_reg;
`endif
         default: txd = 1'b1;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      abort_next   = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_next  = parity_reg;
`endif
      // Lock loss overrides everything, including an accept landing in the same cycle.
      if (!lk_s && (tx_busy || accept)) begin
         state_next   = IDLE;
         bit_cnt_next = 8'd0;
         bit_idx_next = '0;
         abort_next   = 1'b1;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_next   = START;
                  bit_cnt_next = 8'd0;
                  shift_next   = tx_data;
`ifdef UART_TX_PARITY_EN
                  parity_next  = ^tx_data;
`endif
               end
            end
            START: begin
               if (last_tick) begin
                  state_next   = DATA;
                  bit_cnt_next = 8'd0;
                  bit_idx_next = '0;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 8'd1;
               end
            end
            DATA: begin
               if (last_tick) begin
                  bit_cnt_next = 8'd0;
                  shift_next   = shift_reg >> 1;
                  if (bit_idx_reg == IDX_LAST) begin
                     bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
                     state_next   = PARITY;
`else
                     state_next   = STOP;
`endif
                  end else begin
                     bit_idx_next = bit_idx_reg + 1'b1;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + 8'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (last_tick) begin
                  state_next   = STOP;
                  bit_cnt_next = 8'd0;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 8'd1;
               end
            end
`endif
            STOP: begin
               if (last_tick) begin
                  bit_cnt_next = 8'd0;
                  // Accepting in the last stop cycle chains the next start bit with no idle gap.
                  if (accept) begin
                     state_next  = START;
                     shift_next  = tx_data;
`ifdef UART_TX_PARITY_EN
                     parity_next = ^tx_data;
`endif
                  end else begin
                     state_next  = IDLE;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + 8'd1;
               end
            end
            default: begin
               state_next   = IDLE;
               bit_cnt_next = 8'd0;
               bit_idx_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= 8'd0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         abort_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         abort_reg   <= abort_next;
`ifdef UART_TX_PARITY_EN
         parity_reg  <= parity_next;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_lockgate.sv
// Self-checking bench for uart_tx_lockgate: a line-level model (queue of expected txd samples
// plus a lock run-length counter) is compared against the DUT outputs every cycle.
module tb_uart_tx_lockgate;

   localparam int CPB = 5;
   localparam int DB  = 8;
   localparam int LW  = 16;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME = (DB + 3) * CPB;
`else
   localparam int FRAME = (DB + 2) * CPB;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pll_locked = 1'b0;
   logic [DB-1:0] tx_data = '0;
   logic          tx_valid = 1'b0;
   logic          tx_ready, txd, tx_busy, link_up, tx_abort;
   logic [4:0]    obs_vec;

   int checks = 0;
   int fails  = 0;

   // model state
   bit m_s1, m_lks, m_abort, m_acc;
   int m_cnt;
   bit q[$];

   always #5 clk = ~clk;

   uart_tx_lockgate #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .LOCK_WAIT(LW)) dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy),
      .link_up(link_up), .tx_abort(tx_abort)
   );

   assign obs_vec = {txd, tx_ready, tx_busy, link_up, tx_abort};

   function automatic logic [4:0] exp_vec();
      bit ln;
      ln = (m_cnt == LW);
      return {(q.size() > 0) ? q[0] : 1'b1, ln && (q.size() <= 1), q.size() > 0, ln, m_abort};
   endfunction

   task automatic push_frame(input logic [DB-1:0] b);
      for (int i = 0; i < CPB; i++) q.push_back(1'b0);
      for (int j = 0; j < DB; j++)
         for (int i = 0; i < CPB; i++) q.push_back(b[j]);
`ifdef UART_TX_PARITY_EN
      for (int i = 0; i < CPB; i++) q.push_back(^b);
`endif
      for (int i = 0; i < CPB; i++) q.push_back(1'b1);
   endtask

   // Advance DUT and model by one clock edge; outputs are then stable 1 time unit after the edge.
   task automatic cycle();
      bit ln, acc;
      @(posedge clk);
      ln    = (m_cnt == LW);
      acc   = tx_valid && ln && (q.size() <= 1);
      m_acc = acc;
      if (!m_lks && (q.size() > 0 || acc)) begin
         m_abort = 1'b1;
         q.delete();
      end else begin
         m_abort = 1'b0;
         if (q.size() > 0) q.delete(0);
         if (acc) push_frame(tx_data);
      end
      if (!m_lks) m_cnt = 0;
      else if (m_cnt < LW) m_cnt++;
      m_lks = m_s1;
      m_s1  = pll_locked;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pll_locked = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (txd !== 1'b1)      begin fails++; $display("FAIL reset_txd: got %b expected 1", txd); end
      checks++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", tx_ready); end
      checks++; if (tx_busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
      checks++; if (link_up !== 1'b0)  begin fails++; $display("FAIL reset_link: got %b expected 0", link_up); end
      checks++; if (tx_abort !== 1'b0) begin fails++; $display("FAIL reset_abort: got %b expected 0", tx_abort); end
      @(negedge clk);
      rst_n = 1'b1; pll_locked = 1'b0; tx_valid = 1'b0;
      m_s1 = 0; m_lks = 0; m_abort = 0; m_acc = 0; m_cnt = 0; q.delete();
      $display("reset: outputs checked, released");
   endtask

   // Raise lock and count edges until link_up; expect the 2-flop sync plus LOCK_WAIT edges.
   task automatic relock(input string tag);
      int n, rise, busy_seen;
      rise = -1; busy_seen = 0;
      pll_locked = 1'b1;
      for (n = 1; n <= 40 && rise < 0; n++) begin
         cycle();
         checks++;
         if (obs_vec !== exp_vec()) begin
            fails++; $display("FAIL %s_vec cyc %0d: got %b expected %b", tag, n, obs_vec, exp_vec());
         end
         if (tx_busy) busy_seen++;
         if (link_up === 1'b1) rise = n;
      end
      checks++;
      if (rise != LW + 2) begin fails++; $display("FAIL %s_latency: got %0d expected %0d", tag, rise, LW + 2); end
      checks++;
      if (busy_seen != 0) begin fails++; $display("FAIL %s_busy: got %0d busy cycles expected 0", tag, busy_seen); end
      $display("%s: link_up after %0d edges", tag, rise);
   endtask

   task automatic test_lock_qual();
      relock("lock_qual");
   endtask

   task automatic wait_accept(input string tag);
      bit got;
      got = 0;
      for (int n = 0; n < 100 && !got; n++) begin
         cycle();
         checks++;
         if (obs_vec !== exp_vec()) begin
            fails++; $display("FAIL %s_wait_vec: got %b expected %b", tag, obs_vec, exp_vec());
         end
         got = m_acc;
      end
      checks++;
      if (!got) begin fails++; $display("FAIL %s_accept_timeout: got none expected acceptance", tag); end
   endtask

   task automatic test_frame(input logic [DB-1:0] b, input bit exp_par);
      int busy;
      busy = 0;
      tx_data = b; tx_valid = 1'b1;
      wait_accept("frame");
      tx_valid = 1'b0;
      for (int k = 0; k < FRAME + 3; k++) begin
         checks++;
         if (obs_vec !== exp_vec()) begin
            fails++; $display("FAIL frame_vec byte %h cyc %0d: got %b expected %b", b, k, obs_vec, exp_vec());
         end
         if (k == 0) begin
            checks++;
            if (txd !== 1'b0) begin fails++; $display("FAIL frame_start_latency: got txd %b expected 0", txd); end
         end
`ifdef UART_TX_PARITY_EN
         if (k == (1 + DB) * CPB) begin
            checks++;
            if (txd !== exp_par) begin fails++; $display("FAIL parity_bit byte %h: got %b expected %b", b, txd, exp_par); end
         end
`endif
         if (tx_busy) busy++;
         cycle();
      end
      checks++;
      if (busy != FRAME) begin fails++; $display("FAIL frame_busy_len byte %h: got %0d expected %0d", b, busy, FRAME); end
      $display("frame %h: busy %0d cycles (parity ref %0d)", b, busy, exp_par);
   endtask

   task automatic test_back_to_back();
      int run;
      bit gap;
      run = 0; gap = 0;
      tx_data = 8'h00; tx_valid = 1'b1;
      wait_accept("b2b");
      tx_data = 8'hFF;
      for (int k = 0; k < 2 * FRAME + 5; k++) begin
         checks++;
         if (obs_vec !== exp_vec()) begin
            fails++; $display("FAIL b2b_vec cyc %0d: got %b expected %b", k, obs_vec, exp_vec());
         end
         if (tx_busy && !gap) run++;
         else if (!tx_busy) gap = 1;
         cycle();
         if (m_acc) tx_valid = 1'b0;
      end
      checks++;
      if (run != 2 * FRAME) begin fails++; $display("FAIL b2b_run: got %0d expected %0d", run, 2 * FRAME); end
      $display("back_to_back: contiguous busy %0d cycles", run);
   endtask

   task automatic test_abort();
      int aborts, ak;
      aborts = 0; ak = -1;
      tx_data = 8'h5A; tx_valid = 1'b1;
      wait_accept("abort");
      tx_valid = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         checks++;
         if (obs_vec !== exp_vec()) begin
            fails++; $display("FAIL abort_vec cyc %0d: got %b expected %b", k, obs_vec, exp_vec());
         end
         if (tx_abort) begin aborts++; ak = k; end
         if (k == 23) begin
            checks++;
            if ({txd, tx_busy, link_up, tx_ready} !== 4'b1000) begin
               fails++; $display("FAIL abort_state: got %b expected 1000", {txd, tx_busy, link_up, tx_ready});
            end
         end
         // Low is sampled at the edge ending cycle 20, reaches lk_s one edge later, aborts the edge after.
         if (k == 20) pll_locked = 1'b0;
         cycle();
      end
      checks++;
      if (aborts != 1 || ak != 23) begin
         fails++; $display("FAIL abort_pulse: got %0d pulses at %0d expected 1 at 23", aborts, ak);
      end
      $display("abort: %0d pulse(s) at frame cycle %0d", aborts, ak);
      relock("relock");
   endtask

   task automatic test_simultaneous();
      pll_locked = 1'b0; tx_valid = 1'b0;
      cycle();
      cycle();
      // lk_s is now low while link_up is still registered high, so tx_ready is up for one cycle.
      checks++;
      if (tx_ready !== 1'b1) begin fails++; $display("FAIL simul_ready: got %b expected 1", tx_ready); end
      tx_data = 8'h3C; tx_valid = 1'b1;
      cycle();
      tx_valid = 1'b0;
      checks++;
      if ({tx_abort, tx_busy, txd} !== 3'b101) begin
         fails++; $display("FAIL simul_abort: got %b expected 101", {tx_abort, tx_busy, txd});
      end
      checks++;
      if (obs_vec !== exp_vec()) begin fails++; $display("FAIL simul_vec: got %b expected %b", obs_vec, exp_vec()); end
      $display("simultaneous: abort=%b busy=%b", tx_abort, tx_busy);
   endtask

   task automatic test_no_lock();
      int bad;
      bad = 0;
      pll_locked = 1'b0; tx_valid = 1'b0;
      repeat (5) cycle();
      tx_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tx_data = 8'($urandom);
         cycle();
         checks++;
         if (obs_vec !== exp_vec()) begin
            fails++; $display("FAIL nolock_vec cyc %0d: got %b expected %b", k, obs_vec, exp_vec());
         end
         if (txd !== 1'b1 || tx_abort !== 1'b0 || tx_busy !== 1'b0) bad++;
      end
      tx_valid = 1'b0;
      checks++;
      if (bad != 0) begin fails++; $display("FAIL nolock_line: got %0d bad cycles expected 0", bad); end
      $display("no_lock: %0d bad cycles", bad);
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      pll_locked = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) pll_locked = ~pll_locked;
         tx_valid = ($urandom_range(0, 2) != 0);
         tx_data  = 8'($urandom);
         cycle();
         checks++;
         if (obs_vec !== exp_vec()) begin
            fails++; errs++;
            if (errs <= 10) $display("FAIL random_vec cyc %0d: got %b expected %b", k, obs_vec, exp_vec());
         end
      end
      tx_valid = 1'b0;
      $display("random: 3000 cycles, %0d divergences", errs);
   endtask

   initial begin
      test_reset();
      test_lock_qual();
      test_frame(8'hA5, 1'b0);
      test_frame(8'h07, 1'b1);
      test_frame(8'h03, 1'b0);
      test_back_to_back();
      test_abort();
      test_simultaneous();
      test_no_lock();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
